// File: rtl/paint_pkg.sv
// -----------------------------------------------------------------------------
// paint_pkg
// Shared constants and types for the canvas writer.
//   - Framebuffer geometry (160x120, one byte per pixel, 15-bit word address)
//   - Cursor sample record {x, y, colour} as delivered by the cursor block
//   - FSM state type; the CLR state exists only when CANVAS_CLEAR_EN is defined
//   - fb_addr(): y*160+x built from shifts and adds (no multiplier)
// -----------------------------------------------------------------------------
package paint_pkg;

    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int FB_DEPTH = 19200;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 8;
    localparam int COORD_W  = 8;
    localparam int SAMPLE_W = 2 * COORD_W + COLOR_W;

    localparam logic [COLOR_W-1:0] CLEAR_COLOR   = 8'h00;
    // Last-written coordinates come out of reset at an impossible position so
    // the very first paint, even at (0,0), is seen as new.
    localparam logic [COORD_W-1:0] LW_COORD_INIT = 8'hFF;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } sample_t;

    localparam sample_t LAST_WRITTEN_INIT = '{x: LW_COORD_INIT, y: LW_COORD_INIT, color: '0};

`ifdef CANVAS_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_CLR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2
    } state_t;
`endif

    // y*160 + x == (y<<7) + (y<<5) + x. With y < 120 the result fits 15 bits.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] y_w;
        logic [ADDR_W-1:0] x_w;
        y_w = {{(ADDR_W-COORD_W){1'b0}}, y};
        x_w = {{(ADDR_W-COORD_W){1'b0}}, x};
        return (y_w << 7) + (y_w << 5) + x_w;
    endfunction

endpackage

// File: rtl/coord_sync.sv
// -----------------------------------------------------------------------------
// coord_sync
// Two-flop synchroniser for the 24-bit cursor sample {x, y, colour} coming
// from the slow cursor clock, followed by a stability detector.
// Ports:
//   clk_i     system clock
//   rst_ni    synchronous active-low reset
//   data_i    raw {x, y, colour} from the cursor block
//   sample_o  synchronised sample (second flop)
//   stable_o  sample equal to its value one cycle earlier
// -----------------------------------------------------------------------------
module coord_sync
    import paint_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                stable_o
);

    logic [SAMPLE_W-1:0] sync1_q;
    logic [SAMPLE_W-1:0] sync2_q;
    logic [SAMPLE_W-1:0] prev_q;
    // Counts the first edges after reset. Until the chain has been refilled
    // with real input data, the all-zero reset contents would look like a
    // stable (0,0,colour 0) sample and trigger a spurious paint.
    logic [1:0]          fill_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign sample_o = sync2_q;
    assign stable_o = (fill_q == 2'd3) && (sync2_q == prev_q);

endmodule

// File: rtl/canvas_writer.sv
// -----------------------------------------------------------------------------
// canvas_writer
// Turns cursor position/colour samples into single-byte framebuffer writes.
// A write is issued when the pen is down and the stable sample differs from
// the last one written; off-canvas samples are dropped.
// Optional feature (macro CANVAS_CLEAR_EN): CLEAR request fills the whole
// framebuffer with CLEAR_COLOR, one handshake per pixel.
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   xCoord, yCoord  cursor column/row (slow clock domain)
//   RGBw            pen colour RRRGGGBB (slow clock domain)
//   PAINT           pen down
//   WE_ACK          framebuffer accepted current request
//   ADDR, DATA      framebuffer write address/data
//   WE_REQ          write request, held until WE_ACK
//   BUSY            FSM not idle
//   CLEAR           clear-screen request (CANVAS_CLEAR_EN only)
// -----------------------------------------------------------------------------
module canvas_writer
    import paint_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        xCoord,
    input  logic [7:0]        yCoord,
    input  logic [7:0]        RGBw,
    input  logic              PAINT,
    input  logic              WE_ACK,
`ifdef CANVAS_CLEAR_EN
    input  logic              CLEAR,
`endif
    output logic [14:0]       ADDR,
    output logic [7:0]        DATA,
    output logic              WE_REQ,
    output logic              BUSY
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [COLOR_W-1:0]  data_q;
    logic                we_req_q;
    sample_t             last_q;    // last sample actually written
    sample_t             cand_q;    // sample being evaluated / written
    // Most recent off-canvas sample. Without it a parked out-of-range cursor
    // would re-enter CHECK every other cycle, since last_q never matches it.
    sample_t             drop_q;

    sample_t             sample;
    logic                stable;
    logic                new_sample;
    logic                in_range;

    coord_sync u_sync (
        .clk_i    (CLK),
        .rst_ni   (RST_N),
        .data_i   ({xCoord, yCoord, RGBw}),
        .sample_o (sample),
        .stable_o (stable)
    );

    assign new_sample = PAINT && stable && (sample != last_q) && (sample != drop_q);
    assign in_range   = (cand_q.x < COORD_W'(H_RES)) && (cand_q.y < COORD_W'(V_RES));

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            we_req_q <= 1'b0;
            last_q   <= LAST_WRITTEN_INIT;
            cand_q   <= '0;
            drop_q   <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef CANVAS_CLEAR_EN
                    if (CLEAR) begin
                        // Clear takes priority; addr_q doubles as the fill counter.
                        state_q  <= ST_CLR;
                        addr_q   <= '0;
                        data_q   <= CLEAR_COLOR;
                        we_req_q <= 1'b1;
                    end else
`endif
                    if (new_sample) begin
                        cand_q  <= sample;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (in_range) begin
                        addr_q   <= fb_addr(cand_q.x, cand_q.y);
                        data_q   <= cand_q.color;
                        we_req_q <= 1'b1;
                        state_q  <= ST_REQ;
                    end else begin
                        drop_q  <= cand_q;
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Address/data stay frozen here regardless of PAINT or
                    // cursor motion; only the handshake ends the write.
                    if (WE_ACK) begin
                        we_req_q <= 1'b0;
                        last_q   <= cand_q;
                        state_q  <= ST_IDLE;
                    end
                end
`ifdef CANVAS_CLEAR_EN
                ST_CLR: begin
                    if (WE_ACK) begin
                        if (addr_q == ADDR_W'(FB_DEPTH - 1)) begin
                            we_req_q <= 1'b0;
                            // Canvas is blank now, so any pen position must repaint.
                            last_q   <= LAST_WRITTEN_INIT;
                            state_q  <= ST_IDLE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ADDR   = addr_q;
    assign DATA   = data_q;
    assign WE_REQ = we_req_q;
    assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_canvas_writer.sv
module tb_canvas_writer;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  xCoord, yCoord, RGBw;
    logic        PAINT, WE_ACK;
    logic [14:0] ADDR;
    logic [7:0]  DATA;
    logic        WE_REQ, BUSY;
`ifdef CANVAS_CLEAR_EN
    logic        CLEAR;
`endif

    always #5 CLK = ~CLK;

    canvas_writer dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .xCoord (xCoord),
        .yCoord (yCoord),
        .RGBw   (RGBw),
        .PAINT  (PAINT),
        .WE_ACK (WE_ACK),
`ifdef CANVAS_CLEAR_EN
        .CLEAR  (CLEAR),
`endif
        .ADDR   (ADDR),
        .DATA   (DATA),
        .WE_REQ (WE_REQ),
        .BUSY   (BUSY)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Edges counted from the negedge where stimulus was applied; 0 = timed out.
    task automatic wait_req(input int bound, output int lat);
        lat = 0;
        for (int e = 1; e <= bound; e++) begin
            if (lat == 0) begin
                @(posedge CLK);
                #1;
                if (WE_REQ) lat = e;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  x, y, c;
        logic        paint;
        int          ack_dly;
        logic        exp_wr;
        int          exp_lat;
        logic [14:0] exp_addr;
        int          exp_busy;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, busy_cnt, wr_seen;

        vecs[0] = '{"origin",      8'd0,   8'd0,   8'hE0, 1'b1, 0, 1'b1, 5, 15'd0,     0};
        vecs[1] = '{"corner",      8'd159, 8'd119, 8'h1C, 1'b1, 7, 1'b1, 5, 15'd19199, 0};
        vecs[2] = '{"x_oob",       8'd160, 8'd10,  8'h1C, 1'b1, 0, 1'b0, 0, 15'd0,     1};
        vecs[3] = '{"y_oob",       8'd10,  8'd200, 8'h07, 1'b1, 0, 1'b0, 0, 15'd0,     1};
        vecs[4] = '{"p3_2",        8'd3,   8'd2,   8'h55, 1'b1, 2, 1'b1, 5, 15'd323,   0};
        vecs[5] = '{"recolour",    8'd3,   8'd2,   8'hAA, 1'b1, 0, 1'b1, 5, 15'd323,   0};
        vecs[6] = '{"unchanged",   8'd3,   8'd2,   8'hAA, 1'b1, 0, 1'b0, 0, 15'd0,     0};
        vecs[7] = '{"p100_50",     8'd100, 8'd50,  8'hFF, 1'b1, 1, 1'b1, 5, 15'd8100,  0};
        vecs[8] = '{"pen_up",      8'd1,   8'd1,   8'h11, 1'b0, 0, 1'b0, 0, 15'd0,     0};
        vecs[9] = '{"pen_down",    8'd1,   8'd1,   8'h11, 1'b1, 0, 1'b1, 2, 15'd161,   0};

        RST_N = 1'b0; xCoord = '0; yCoord = '0; RGBw = '0; PAINT = 1'b0; WE_ACK = 1'b0;
`ifdef CANVAS_CLEAR_EN
        CLEAR = 1'b0;
`endif
        repeat (3) @(posedge CLK);
        #1;
        check("rst_addr",   32'(ADDR),   32'd0);
        check("rst_data",   32'(DATA),   32'd0);
        check("rst_we_req", 32'(WE_REQ), 32'd0);
        check("rst_busy",   32'(BUSY),   32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            @(negedge CLK);
            xCoord = vecs[i].x; yCoord = vecs[i].y; RGBw = vecs[i].c;
            PAINT  = vecs[i].paint;
            WE_ACK = (vecs[i].ack_dly == 0);
            if (vecs[i].exp_wr) begin
                wait_req(12, lat);
                check({vecs[i].name, "_lat"},  32'(lat),  32'(vecs[i].exp_lat));
                check({vecs[i].name, "_addr"}, 32'(ADDR), 32'(vecs[i].exp_addr));
                check({vecs[i].name, "_data"}, 32'(DATA), 32'(vecs[i].c));
                for (int k = 0; k < vecs[i].ack_dly; k++) begin
                    @(posedge CLK);
                    #1;
                    check({vecs[i].name, "_hold"}, {16'(WE_REQ), ADDR[7:0], DATA},
                          {16'd1, vecs[i].exp_addr[7:0], vecs[i].c});
                end
                if (vecs[i].ack_dly > 0) begin
                    @(negedge CLK);
                    WE_ACK = 1'b1;
                end
                @(posedge CLK);
                #1;
                check({vecs[i].name, "_release"}, {31'd0, WE_REQ}, 32'd0);
                check({vecs[i].name, "_idle"},    {31'd0, BUSY},   32'd0);
            end else begin
                busy_cnt = 0; wr_seen = 0;
                repeat (12) begin
                    @(posedge CLK);
                    #1;
                    busy_cnt += int'(BUSY);
                    wr_seen  += int'(WE_REQ);
                end
                check({vecs[i].name, "_nowrite"}, 32'(wr_seen),  32'd0);
                check({vecs[i].name, "_busy"},    32'(busy_cnt), 32'(vecs[i].exp_busy));
            end
        end

        // Cursor moves twice while a write is pending: in-flight write frozen,
        // newest position written afterwards.
        @(negedge CLK);
        xCoord = 8'd5; yCoord = 8'd5; RGBw = 8'h33; PAINT = 1'b1; WE_ACK = 1'b0;
        wait_req(12, lat);
        check("move_lat", 32'(lat), 32'd5);
        check("move_addr0", 32'(ADDR), 32'd805);
        @(negedge CLK); xCoord = 8'd6;
        repeat (6) @(posedge CLK);
        #1;
        check("move_frozen6", {16'(WE_REQ), 16'(ADDR)}, {16'd1, 16'd805});
        @(negedge CLK); xCoord = 8'd7;
        repeat (6) @(posedge CLK);
        #1;
        check("move_frozen7", {16'(WE_REQ), 16'(ADDR)}, {16'd1, 16'd805});
        @(negedge CLK); WE_ACK = 1'b1;
        @(posedge CLK);
        #1;
        check("move_release", {31'd0, WE_REQ}, 32'd0);
        @(negedge CLK); WE_ACK = 1'b0;
        wait_req(12, lat);
        check("move_lat2", 32'(lat), 32'd2);
        check("move_addr1", 32'(ADDR), 32'd807);
        check("move_data1", 32'(DATA), 32'h33);
        @(negedge CLK); WE_ACK = 1'b1;
        wr_seen = 0;
        @(posedge CLK);
        repeat (10) begin
            @(posedge CLK);
            #1;
            wr_seen += int'(WE_REQ);
        end
        check("move_no_more", 32'(wr_seen), 32'd0);

        // Pen lifted while a write is pending: write still completes.
        @(negedge CLK);
        xCoord = 8'd20; yCoord = 8'd1; RGBw = 8'h0F; WE_ACK = 1'b0;
        wait_req(12, lat);
        check("penup_addr", 32'(ADDR), 32'd180);
        @(negedge CLK); PAINT = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("penup_hold", {16'(WE_REQ), 16'(ADDR)}, {16'd1, 16'd180});
        @(negedge CLK); WE_ACK = 1'b1;
        @(posedge CLK);
        #1;
        check("penup_release", {31'd0, WE_REQ}, 32'd0);
        @(negedge CLK); PAINT = 1'b1;

        // Reset during a pending write, then repaint of the same spot.
        @(negedge CLK);
        xCoord = 8'd40; yCoord = 8'd3; RGBw = 8'h77; WE_ACK = 1'b0;
        wait_req(12, lat);
        check("rstreq_addr", 32'(ADDR), 32'd520);
        @(negedge CLK); RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("rstreq_we_req", {31'd0, WE_REQ}, 32'd0);
        check("rstreq_busy",   {31'd0, BUSY},   32'd0);
        check("rstreq_addrdata", {16'(ADDR), 16'(DATA)}, 32'd0);
        @(negedge CLK); RST_N = 1'b1;
        wait_req(12, lat);
        check("rstreq_lat", 32'(lat), 32'd5);
        check("rstreq_rewrite", {16'(ADDR), 16'(DATA)}, {16'd520, 16'h77});
        @(negedge CLK); WE_ACK = 1'b1;
        @(posedge CLK);
        #1;
        check("rstreq_release", {31'd0, WE_REQ}, 32'd0);

`ifdef CANVAS_CLEAR_EN
        begin
            int n, bad, cyc;
            @(negedge CLK);
            PAINT = 1'b0; WE_ACK = 1'b1; CLEAR = 1'b1;
            @(posedge CLK);
            #1;
            CLEAR = 1'b0;
            n = 0; bad = 0; cyc = 0;
            while (BUSY && cyc < 20100) begin
                if (WE_REQ) begin
                    if (ADDR != 15'(n) || DATA != 8'h00) bad++;
                    n++;
                end
                @(posedge CLK);
                #1;
                cyc++;
            end
            check("clr_count", 32'(n), 32'd19200);
            check("clr_bad", 32'(bad), 32'd0);
            check("clr_done", {30'd0, BUSY, WE_REQ}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/canvas_writer.md
CANVAS_WRITER -- requirements
Module: canvas_writer

Interface
REQ-001 CLK  in  1  sole clock; all logic on rising edge.
REQ-002 RST_N  in  1  reset, synchronous, active-low.
REQ-003 xCoord  in  8  cursor column from cursor block; valid range 0..159.
REQ-004 yCoord  in  8  cursor row from cursor block; valid range 0..119.
REQ-005 RGBw  in  8  pen colour, RRRGGGBB.
REQ-006 PAINT  in  1  pen down; 1 = paint cursor position.
REQ-007 WE_ACK  in  1  framebuffer write port accepted current request.
REQ-008 ADDR  out  15  framebuffer word address.
REQ-009 DATA  out  8  framebuffer write data.
REQ-010 WE_REQ  out  1  write request; held until WE_ACK.
REQ-011 BUSY  out  1  high whenever state is not IDLE.
REQ-012 CLEAR  in  1  clear-screen request; port exists only with CANVAS_CLEAR_EN.

Function
REQ-013 xCoord/yCoord/RGBw SHALL pass a 2-flop synchroniser; the cursor block runs on a slow derived clock.
REQ-014 A sample SHALL be "stable" when synchroniser outputs are equal on two consecutive cycles.
REQ-015 FSM states: IDLE, CHECK, REQ, CLR (CLR only with CANVAS_CLEAR_EN).
REQ-016 IDLE->CHECK when PAINT=1 and the stable sample differs from last-written {x,y,colour}.
REQ-017 CHECK: if x<160 and y<120, load ADDR=y*160+x, DATA=colour, go REQ; else drop sample, return IDLE with last-written unchanged.
REQ-018 ADDR SHALL be computed as (y<<7)+(y<<5)+x, 15 bits, no multiplier.
REQ-019 WE_REQ SHALL rise on the 5th CLK edge after the input change: 2 sync, 1 stability, 1 IDLE->CHECK, 1 CHECK->REQ.
REQ-020 In REQ, ADDR/DATA/WE_REQ SHALL hold constant until WE_ACK=1 is sampled.
REQ-021 WE_ACK=1 sampled in REQ: WE_REQ=0 next edge, last-written updated, state IDLE.
REQ-022 WE_ACK outside REQ/CLR SHALL be ignored.
REQ-023 Input changes during CHECK/REQ SHALL NOT alter the in-flight write; the newest stable sample is evaluated on return to IDLE; intermediate samples may be lost.
REQ-024 PAINT falling during REQ SHALL NOT abort the write.
REQ-025 Same coordinate with changed colour SHALL trigger a write; unchanged triple SHALL NOT.

Reset
REQ-026 RST_N=0 at an edge: ADDR=0, DATA=0, WE_REQ=0, BUSY=0, state IDLE, sync flops 0, last-written x=y=8'hFF, colour=0.
REQ-027 Reset mid-REQ or mid-CLR SHALL abandon the operation; WE_REQ low after that edge.
REQ-028 First PAINT after reset at (0,0) SHALL write, since last-written is 8'hFF.

Configuration
REQ-029 Macro CANVAS_CLEAR_EN.
REQ-030 Defined: CLEAR=1 in IDLE enters CLR, priority over paint; writes DATA=8'h00 at ADDR 0..19199 ascending, one per WE_ACK handshake; then last-written reset to 8'hFF, return IDLE.
REQ-031 Defined: CLEAR ignored outside IDLE; paint requests wait until CLR completes.
REQ-032 Undefined: no CLEAR port, no CLR state, no clear counter logic.

Structure
REQ-033 Package paint_pkg: H_RES=160, V_RES=120, FB_DEPTH=19200, ADDR_W=15, COLOR_W=8, CLEAR_COLOR=8'h00, FSM state type.
REQ-034 Sub-module coord_sync: 24-bit 2-flop synchroniser plus stability compare; outputs stable flag and sample.

Verification
REQ-035 Reset, PAINT=1, x=0,y=0,RGBw=E0, WE_ACK tied 1 -> one write ADDR=0 DATA=E0; WE_REQ rises edge 5.
REQ-036 x=159,y=119,RGBw=1C, WE_ACK delayed 7 cycles -> ADDR=19199 DATA=1C held 7 cycles, single write.
REQ-037 x=160,y=10, PAINT=1 -> no WE_REQ; BUSY pulses 1 cycle (CHECK).
REQ-038 Write pending at (5,5); move to (6,5) then (7,5) before ACK -> writes 805 then 807; 806 may be skipped.
REQ-039 RST_N=0 while WE_REQ=1 -> WE_REQ=0 next edge; repaint at same spot rewrites.
REQ-040 CANVAS_CLEAR_EN, CLEAR=1 pulse, WE_ACK tied 1 -> 19200 writes DATA=00, ADDR 0..19199, BUSY low after last.
